unidade_controle: RTL



---
 rtl/unidade_controle.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/unidade_controle.sv
// unidade_controle: handshaked control FSM (IDLE/EXEC/WB) that accepts one
// instruction at a time, sequences multi-cycle ALU ops and a single
// write-back cycle, and drives one-hot register load enables.
// Optional feature macro: UC_ILLEGAL_CHK_EN. When it is defined, an
// out-of-range destination is flagged on `illegal` and the instruction is
// dropped. When it is not defined, `illegal` is tied low and the
// out-of-range write is silently dropped in WB.
module unidade_controle #(
  parameter  int OP_W     = 4,
  parameter  int NUM_REGS = 2,
  parameter  int ALU_LAT  = 1,
  localparam int SEL_W    = $clog2(NUM_REGS),
  localparam int CNT_W    = $clog2(ALU_LAT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OP_W-1:0]     instr_op,
  input  logic [SEL_W-1:0]    instr_dst,
  output logic [NUM_REGS-1:0] reg_load,
  output logic [OP_W-1:0]     ula,
  output logic                ula_start,
  output logic                busy,
  output logic                illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [OP_W-1:0]    op_q, op_n;
  logic [SEL_W-1:0]   dst_q, dst_n;
  logic               ready_n, start_n, busy_n;
  logic [NUM_REGS-1:0] load_n;
  logic [OP_W-1:0]    ula_n;
  logic               bad_dst;

  // One-hot decode of a register index; indices past NUM_REGS decode to 0,
  // which is what drops an out-of-range write in WB.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] d);
    logic [NUM_REGS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++) r[i] = (d == SEL_W'(i));
    return r;
  endfunction

`ifdef UC_ILLEGAL_CHK_EN
  localparam logic [SEL_W:0] NREGS = (SEL_W+1)'(NUM_REGS);
  logic illegal_n;

  // Out-of-range destination at acceptance is rejected without a write.
  assign bad_dst = ({1'b0, instr_dst} >= NREGS);

  // Illegal flag: one registered pulse in the cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal <= 1'b0;
    else        illegal <= illegal_n;
  end
`else
  assign bad_dst = 1'b0;
  assign illegal = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    dst_n   = dst_q;
    ready_n = 1'b0;
    start_n = 1'b0;
    load_n  = '0;
    ula_n   = '0;
`ifdef UC_ILLEGAL_CHK_EN
    illegal_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (instr_valid && instr_ready) begin
          op_n  = instr_op;
          dst_n = instr_dst;
          if (bad_dst) begin
`ifdef UC_ILLEGAL_CHK_EN
            illegal_n = 1'b1;
`endif
          end else if (instr_op == '0) begin
            // LD: straight to write-back, ALU code stays 0
            state_n = WB;
            ready_n = 1'b0;
            load_n  = onehot(instr_dst);
          end else if (instr_op != OP_W'(1)) begin
            // ALU op: start pulse on the first EXEC cycle only
            state_n = EXEC;
            ready_n = 1'b0;
            ula_n   = instr_op;
            start_n = 1'b1;
            cnt_n   = CNT_W'(ALU_LAT - 1);
          end
          // NOP: accepted, nothing changes, ready stays high
        end
      end
      EXEC: begin
        ula_n = op_q;
        if (cnt == '0) begin
          state_n = WB;
          load_n  = onehot(dst_q);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      WB: begin
        state_n = IDLE;
        ready_n = 1'b1;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State, captured instruction and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= '0;
      dst_q       <= '0;
      instr_ready <= 1'b0;
      reg_load    <= '0;
      ula         <= '0;
      ula_start   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      op_q        <= op_n;
      dst_q       <= dst_n;
      instr_ready <= ready_n;
      reg_load    <= load_n;
      ula         <= ula_n;
      ula_start   <= start_n;
      busy        <= busy_n;
    end
  end

endmodule
